// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths and the result-stage entry layout
package alu_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W = 4;
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic zero;
    logic [ALU_DATA_W-1:0] result;
  } alu_res_t;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: ALU-side and writeback-side valid/ready channels of the result stage
interface alu_result_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W = ALU_OP_W
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_result;
  logic in_zero;
  logic [OP_W-1:0] in_op;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_result;
  logic out_zero;
  logic [OP_W-1:0] out_op;
  modport master (
    output in_valid, in_result, in_zero, in_op, out_ready,
    input in_ready, out_valid, out_result, out_zero, out_op
  );
  modport slave (
    input in_valid, in_result, in_zero, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_op
  );
endinterface

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: reset-cleared storage FIFO with registered pointers and occupancy count
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = $bits(alu_res_t)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = count_q + CW'(push_i) - CW'(pop_i);
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU result FIFO with forwarding copy; optional zero-result counter under ALU_ZERO_CNT_EN
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W = ALU_OP_W
) (
  input  logic clk,
  input  logic rst,
  alu_result_stage_if.slave bus,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DATA_W-1:0] fwd_result_o,
  output logic fwd_zero_o
`ifdef ALU_ZERO_CNT_EN
  ,
  output logic [15:0] zero_cnt_o
`endif
);
  localparam int W = OP_W + 1 + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic push, pop;
  logic [W-1:0] head;
  logic [DATA_W-1:0] fwd_result_q, fwd_result_d;
  logic fwd_zero_q, fwd_zero_d;
  // handshake readiness comes from the registered count only
  assign bus.in_ready = count_o != CW'(DEPTH);
  assign bus.out_valid = count_o != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign {bus.out_op, bus.out_zero, bus.out_result} = head;
  alu_res_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .wdata_i({bus.in_op, bus.in_zero, bus.in_result}),
    .rdata_o(head),
    .count_o(count_o)
  );
  always_comb begin
    fwd_result_d = push ? bus.in_result : fwd_result_q;
    fwd_zero_d = push ? bus.in_zero : fwd_zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_result_q <= '0;
      fwd_zero_q <= 1'b0;
    end else begin
      fwd_result_q <= fwd_result_d;
      fwd_zero_q <= fwd_zero_d;
    end
  end
  assign fwd_result_o = fwd_result_q;
  assign fwd_zero_o = fwd_zero_q;
`ifdef ALU_ZERO_CNT_EN
  logic [15:0] zero_cnt_q, zero_cnt_d;
  always_comb zero_cnt_d = (push && bus.in_zero && zero_cnt_q != 16'hFFFF) ? zero_cnt_q + 16'd1 : zero_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_cnt_q <= '0;
    else zero_cnt_q <= zero_cnt_d;
  end
  assign zero_cnt_o = zero_cnt_q;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage
module tb_alu_result_stage;
  logic clk, rst;
  logic [2:0] count;
  logic [31:0] fwd_result;
  logic fwd_zero;
  int checks = 0;
  int failures = 0;
`ifdef ALU_ZERO_CNT_EN
  logic [15:0] zero_cnt;
`endif
  alu_result_stage_if #(.DATA_W(32), .OP_W(4)) bus ();
  alu_result_stage #(.DEPTH(4), .DATA_W(32), .OP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .count_o(count),
    .fwd_result_o(fwd_result),
    .fwd_zero_o(fwd_zero)
`ifdef ALU_ZERO_CNT_EN
    ,
    .zero_cnt_o(zero_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] r, input logic z, input logic [3:0] op);
    bus.in_valid = 1'b1;
    bus.in_result = r;
    bus.in_zero = z;
    bus.in_op = op;
    tick();
    bus.in_valid = 1'b0;
  endtask
  initial begin
    logic [31:0] exp_seq [5];
    logic exp_z [4];
    exp_seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd9};
    exp_z = '{1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_result = '0;
    bus.in_zero = 1'b0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;
    #12 rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_fwd", fwd_result, 0);
    tick();
    push(32'h0000_0005, 1'b0, 4'h6);
    chk("single_valid", bus.out_valid, 1);
    chk("single_result", bus.out_result, 5);
    chk("single_op", bus.out_op, 6);
    chk("single_zero", bus.out_zero, 0);
    chk("single_fwd", fwd_result, 5);
    chk("single_count", count, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_count", count, 0);
    for (int i = 1; i <= 4; i++) push(32'(i), 1'b0, 4'h1);
    chk("full_count", count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    push(32'd9, 1'b0, 4'h1);
    chk("full_reject_count", count, 4);
    chk("full_reject_fwd", fwd_result, 4);
    bus.in_valid = 1'b1;
    bus.in_result = 32'd9;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("fill_pop_valid", bus.out_valid, 1);
      chk("fill_pop_result", bus.out_result, exp_seq[k]);
      if (k == 0) chk("fill_pop_full_ready", bus.in_ready, 0);
      tick();
      if (k == 1) begin
        bus.in_valid = 1'b0;
        chk("fill_late_fwd", fwd_result, 9);
      end
    end
    chk("fill_end_count", count, 0);
    bus.out_ready = 1'b0;
    push(32'd100, 1'b0, 4'h2);
    push(32'd101, 1'b0, 4'h2);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.in_result = 32'(102 + j);
      chk("pp_count", count, 2);
      chk("pp_result", bus.out_result, 32'(100 + j));
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pp_tail0", bus.out_result, 110);
    tick();
    chk("pp_tail1", bus.out_result, 111);
    tick();
    chk("pp_empty", count, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'd0, 1'b1, 4'h3);
    push(32'd7, 1'b0, 4'h3);
    chk("zero_fwd_zero", fwd_zero, 0);
`ifdef ALU_ZERO_CNT_EN
    chk("zero_cnt", zero_cnt, 3);
`endif
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("zero_seq", bus.out_zero, exp_z[k]);
      tick();
    end
    bus.out_ready = 1'b0;
    push(32'h11, 1'b0, 4'h4);
    push(32'h22, 1'b0, 4'h4);
    push(32'h33, 1'b1, 4'h4);
    chk("mid_count", count, 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_fwd", fwd_result, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_out_result", bus.out_result, 0);
`ifdef ALU_ZERO_CNT_EN
    chk("arst_zero_cnt", zero_cnt, 0);
`endif
    #1 rst = 1'b0;
    tick();
    push(32'hDEAD_BEEF, 1'b0, 4'h5);
    chk("post_rst_result", bus.out_result, 32'hDEAD_BEEF);
    chk("post_rst_count", count, 1);
`ifdef ALU_ZERO_CNT_EN
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_result = '0;
    bus.in_zero = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    bus.in_valid = 1'b0;
    chk("zero_cnt_sat", zero_cnt, 16'hFFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
